rf_port_arbiter: RTL and testbench
==================================

# rf_port_arbiter

Shares the register file's single write port and debug read path between the core writeback path and the host/debug access port, after first clearing x1..x31 with a sequenced zero-fill.
- Sits between the core and the 32x32 register file.
- The core normally wins the write port; a starvation counter guarantees the debug port forward progress.
- `core_stall` freezes the PC while the core's writeback is deferred.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- NREG, 32, number of architectural registers (x0 hardwired zero)
- STARVE_MAX, 4, consecutive debug denials before debug is forced to win

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- core_we  in  1  core writeback request this cycle
- core_rd  in  ADDR_W  core destination register
- core_wdata  in  DATA_W  core writeback data
- core_stall  out  1  core writeback not performed this cycle; core must hold PC and inputs
- dbg_req  in  1  debug access request
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug register index
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid
- dbg_rdata  out  DATA_W  registered debug read data
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write index
- rf_wdata  out  DATA_W  register file write data
- rf_raddr  out  ADDR_W  debug read index to register file (combinational read port)
- rf_rdata  in  DATA_W  register file read data, same cycle as rf_raddr
- init_done  out  1  zero-fill complete

## Operation
- **FSM states:** INIT and RUN.
  - Reset enters INIT with `init_idx` = 1.
  - INIT drives `rf_we`=1, `rf_waddr`=`init_idx`, `rf_wdata`=0, then increments `init_idx`.
  - The write with `init_idx`=NREG-1 moves the FSM to RUN.
- **In INIT:** `core_stall`=1 and `dbg_gnt`=0 regardless of inputs.
- **Core-valid write:** `core_we`=1 and `core_rd`≠0. A core write with `core_rd`=0 is dropped: no RF write and no stall.
- **Debug write needs the port:** `dbg_req`=1 and `dbg_we`=1. Debug reads never use the write port, so they are granted immediately in RUN and never stall the core.
- **Arbitration in RUN, when both want the write port:**
  - If `starve_cnt` < STARVE_MAX-1: the core wins, `dbg_gnt`=0, `starve_cnt`+1.
  - Else: debug wins, `dbg_gnt`=1, `core_stall`=1, `starve_cnt` cleared.
- **Only one side wants the port:** that side is granted, `core_stall`=0, and `starve_cnt` is cleared whenever debug is granted or not requesting.
- **Debug write to x0:** the request is granted (`dbg_gnt`=1) but `rf_we`=0.
- **Debug read:** `rf_raddr`=`dbg_addr`. On the grant edge, `dbg_rdata` <= (`dbg_addr`==0 ? 0 : `rf_rdata`) and `dbg_rvalid` <= 1. `dbg_rvalid` is cleared on the next edge unless another read is granted.
- **Combinational outputs:** `rf_we`, `rf_waddr`, `rf_wdata`, `core_stall` and `dbg_gnt` are combinational from state and inputs.
- **Registered outputs:** `dbg_rvalid`, `dbg_rdata` and `init_done` are registered.
- **Reset values:**
  - `init_done`=0, `dbg_rvalid`=0, `dbg_rdata`=0, `starve_cnt`=0.
  - Combinational outputs during reset follow INIT with `init_idx`=1: `rf_we`=1, `rf_waddr`=1, `rf_wdata`=0, `core_stall`=1, `dbg_gnt`=0.

## Timing
- **Zero-fill:** rst_n deasserts before edge 0. Writes x1..x31 occur on edges 0..30; `init_done`=1 after edge 30. The first core write can complete on edge 31.
- **Write latency:** a granted write commits on the same clock edge (0 extra cycles).
- **Read latency:** `dbg_rvalid` and `dbg_rdata` appear one cycle after `dbg_gnt`. Back-to-back reads are granted every cycle.
- **Core/debug write bypass:** a debug read in the same cycle as a core write to the same index returns the old value.
- **Worst-case debug wait:** debug waits at most STARVE_MAX-1 cycles under continuous core writes.
- **Handshake:** `dbg_req`/`dbg_we`/`dbg_addr`/`dbg_wdata` must be held stable until `dbg_gnt`=1. The request is consumed on that edge.
- **Reset mid-operation:** asynchronously aborts everything. INIT restarts from x1, and any pending debug grant or `dbg_rvalid` is lost.

## Structure
- Package `rf_arb_pkg` holds:
  - the state enum (ST_INIT, ST_RUN);
  - the defaults of DATA_W, ADDR_W, NREG and STARVE_MAX;
  - the constant REG_ZERO = 0.
- Sub-module `rf_init_sequencer` owns `init_idx`, the zero-fill write drive and `init_done`. The top level owns arbitration, `starve_cnt` and the read return path.

## Test plan
- **Reset then idle:** 31 writes seen with `rf_waddr` 1..31 and data 0; `init_done` rises after edge 30; `core_stall`=1 throughout INIT.
- **Core write in RUN:** `core_we`=1, `core_rd`=5, `core_wdata`=0xDEADBEEF -> `rf_we`=1, `rf_waddr`=5 same cycle, `core_stall`=0. The same write with `core_rd`=0 -> `rf_we`=0, `core_stall`=0.
- **Starvation, default parameters:** continuous core writes plus a debug write to x7 of 0x12345678. Debug is denied for 3 cycles, granted on the 4th with `core_stall`=1 that cycle; the x7 write commits.
- **Debug read:** write x3=0xCAFEF00D, then read x3 -> `dbg_gnt` same cycle, `dbg_rvalid`=1 and `dbg_rdata`=0xCAFEF00D next cycle. A read of x0 returns 0 even if the RF drives nonzero.
- **Reset mid-operation:** assert `rst_n` at `init_idx`=12 -> outputs return to reset values immediately. After release, zero-fill restarts at x1 and again takes 31 cycles.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file port arbiter.
package rf_arb_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_NREG       = 32;
  localparam int DEF_STARVE_MAX = 4;

  // x0 is hardwired to zero and is never written.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_init_sequencer.sv
// Post-reset zero-fill of x1..x(NREG-1): one register per cycle, then RUN.
module rf_init_sequencer
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREG   = DEF_NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  output logic [ADDR_W-1:0] init_idx,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(REG_ZERO + 1);

  arb_state_e        state_reg;
  logic [ADDR_W-1:0] init_idx_reg;
  logic              init_done_reg;

  // Walk init_idx from x1 to the last register; leaving INIT raises init_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      init_idx_reg  <= FIRST_IDX;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (init_idx_reg == LAST_IDX) begin
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
          end else begin
            init_idx_reg <= init_idx_reg + ADDR_W'(1);
          end
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  assign init_busy = (state_reg == ST_INIT);
  assign init_idx  = init_idx_reg;
  assign init_done = init_done_reg;

endmodule

// File: rtl/rf_port_arbiter.sv
// Arbitrates the register file write port between core writeback and the
// debug port, and returns registered debug read data.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NREG       = DEF_NREG,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              init_done
);

  localparam int                SC_W     = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]   SC_LIMIT = SC_W'(STARVE_MAX - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              init_busy;
  logic [ADDR_W-1:0] init_idx;

  logic [SC_W-1:0]   starve_cnt_reg;
  logic [SC_W-1:0]   starve_cnt_next;
  logic              dbg_rvalid_reg;
  logic [DATA_W-1:0] dbg_rdata_reg;

  logic              core_valid;
  logic              dbg_wr_req;
  logic              dbg_rd_req;
  logic              dbg_write_win;
  logic              read_accept;

  rf_init_sequencer #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .init_idx  (init_idx),
    .init_done (init_done)
  );

  // Debug reads use the RF's combinational read port directly.
  assign rf_raddr = dbg_addr;

  // Write-port arbitration: core preferred, debug forced through once it has
  // been refused STARVE_MAX-1 consecutive times.
  always_comb begin
    core_valid      = core_we && (core_rd != ZERO_IDX);
    dbg_wr_req      = dbg_req && dbg_we;
    dbg_rd_req      = dbg_req && !dbg_we;
    dbg_write_win   = 1'b0;
    read_accept     = 1'b0;
    rf_we           = 1'b0;
    rf_waddr        = init_idx;
    rf_wdata        = '0;
    core_stall      = 1'b0;
    dbg_gnt         = 1'b0;
    starve_cnt_next = '0;

    if (init_busy) begin
      // Zero-fill owns the port; nobody else makes progress.
      rf_we      = 1'b1;
      rf_waddr   = init_idx;
      rf_wdata   = '0;
      core_stall = 1'b1;
    end else begin
      dbg_write_win = dbg_wr_req && (!core_valid || (starve_cnt_reg >= SC_LIMIT));
      read_accept   = dbg_rd_req;
      dbg_gnt       = dbg_rd_req || dbg_write_win;
      core_stall    = core_valid && dbg_write_win;

      if (dbg_write_win) begin
        // A granted debug write to x0 is consumed but never reaches the RF.
        rf_we    = (dbg_addr != ZERO_IDX);
        rf_waddr = dbg_addr;
        rf_wdata = dbg_wdata;
      end else if (core_valid) begin
        rf_we    = 1'b1;
        rf_waddr = core_rd;
        rf_wdata = core_wdata;
      end

      // Count only refusals of a pending debug write; anything else clears.
      if (dbg_wr_req && !dbg_write_win) begin
        starve_cnt_next = starve_cnt_reg + SC_W'(1);
      end
    end
  end

  // Starvation counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Read return: capture RF data on the grant edge, pulse rvalid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rvalid_reg <= 1'b0;
      dbg_rdata_reg  <= '0;
    end else begin
      dbg_rvalid_reg <= read_accept;
      if (read_accept) begin
        dbg_rdata_reg <= (dbg_addr == ZERO_IDX) ? '0 : rf_rdata;
      end
    end
  end

  assign dbg_rvalid = dbg_rvalid_reg;
  assign dbg_rdata  = dbg_rdata_reg;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Randomized bench for rf_port_arbiter with a behavioural reference model.
module tb_rf_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        init_done;

  rf_port_arbiter #(
    .DATA_W(32), .ADDR_W(5), .NREG(32), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The physical register file the arbiter drives. x0 holds junk on purpose.
  logic [31:0] rf_mem [32];
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_raddr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_rf [32];
  bit          m_init;
  int          m_idx;
  int          m_refused;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          obs_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_idx = 1; m_refused = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  // One clock: inputs already applied at the negedge.
  task automatic step();
    bit cw, dw, dr, dwin, e_we, e_gnt, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    #1;
    e_addr = '0; e_data = '0; dw = 0; dr = 0; dwin = 0;
    if (m_init) begin
      e_we = 1; e_addr = 5'(m_idx); e_data = '0; e_stall = 1; e_gnt = 0;
    end else begin
      cw   = core_we && core_rd != 0;
      dw   = dbg_req && dbg_we;
      dr   = dbg_req && !dbg_we;
      // Debug write goes ahead if uncontested or it has waited long enough.
      dwin = dw && (!cw || m_refused >= STARVE_MAX - 1);
      e_gnt   = dr || dwin;
      e_stall = cw && dwin;
      if (dwin) begin
        e_we = dbg_addr != 0; e_addr = dbg_addr; e_data = dbg_wdata;
      end else if (cw) begin
        e_we = 1; e_addr = core_rd; e_data = core_wdata;
      end else begin
        e_we = 0;
      end
    end
    check("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      check("rf_wdata", rf_wdata, e_data);
    end
    check("core_stall", 32'(core_stall), 32'(e_stall));
    check("dbg_gnt", 32'(dbg_gnt), 32'(e_gnt));
    check("init_done", 32'(init_done), 32'(!m_init));
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rvalid));
    check("dbg_rdata", dbg_rdata, m_rdata);
    obs_gnt = dbg_gnt;
    $display("t=%0t init=%0d core_we=%0d rd=%0d dbg_req=%0d we=%0d addr=%0d gnt=%0d stall=%0d rf_we=%0d",
             $time, m_init, core_we, core_rd, dbg_req, dbg_we, dbg_addr, dbg_gnt, core_stall, rf_we);
    @(posedge clk);
    if (!m_init && dr) begin
      m_rvalid = 1;
      m_rdata  = (dbg_addr == 0) ? 32'h0 : m_rf[dbg_addr];
    end else begin
      m_rvalid = 0;
    end
    if (e_we) m_rf[e_addr] = e_data;
    if (!m_init) m_refused = (dw && !dwin) ? m_refused + 1 : 0;
    if (m_init) begin
      if (m_idx == 31) m_init = 0;
      else m_idx++;
    end
    @(negedge clk);
  endtask

  task automatic set_core(input bit we, input logic [4:0] rd, input logic [31:0] d);
    core_we = we; core_rd = rd; core_wdata = d;
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [4:0] a, input logic [31:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd1);
    check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd1);
    check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    check({tag, "_stall"}, 32'(core_stall), 32'd1);
    check({tag, "_gnt"}, 32'(dbg_gnt), 32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'd0);
    check({tag, "_rvalid"}, 32'(dbg_rvalid), 32'd0);
    check({tag, "_rdata"}, dbg_rdata, 32'd0);
  endtask

  task automatic random_inputs();
    set_core($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
    // Debug inputs are held until granted.
    if (!dbg_req || obs_gnt)
      set_dbg($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
  endtask

  initial begin
    int waited;
    rf_mem[0] = 32'hA5A5_5A5A;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    obs_gnt = 0;
    set_core(1, 5'd9, 32'h1111_1111);
    set_dbg(1, 1, 5'd4, 32'h2222_2222);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Zero-fill with the inputs busy: nothing but the fill gets through.
    for (int i = 0; i < 31; i++) begin
      random_inputs();
      step();
    end

    // Core write, then the same write aimed at x0.
    set_dbg(0, 0, 5'd0, 32'h0);
    set_core(1, 5'd5, 32'hDEAD_BEEF); step();
    set_core(1, 5'd0, 32'hDEAD_BEEF); step();

    // Starvation: continuous core writes against a debug write to x7.
    set_dbg(1, 1, 5'd7, 32'h1234_5678);
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      set_core(1, 5'($urandom_range(8, 31)), $urandom);
      waited++;
      step();
      if (obs_gnt) break;
    end
    check("starve_grant_cycle", 32'(waited), 32'(STARVE_MAX));

    // Debug write x3 then read it back; read x7; read x0 (RF holds junk there).
    set_core(0, 5'd0, 32'h0);
    set_dbg(1, 1, 5'd3, 32'hCAFE_F00D); step();
    set_dbg(1, 0, 5'd3, 32'h0); step();
    set_dbg(1, 0, 5'd7, 32'h0); step();
    set_dbg(1, 0, 5'd0, 32'h0); step();
    // Read racing a core write to the same index returns the old value.
    set_core(1, 5'd3, 32'h0BAD_0BAD);
    set_dbg(1, 0, 5'd3, 32'h0); step();
    set_core(0, 5'd0, 32'h0);
    set_dbg(0, 0, 5'd0, 32'h0); step();

    for (int i = 0; i < 300; i++) begin
      random_inputs();
      step();
    end

    // Reset in the middle of zero-fill.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 11; i++) begin
      random_inputs();
      step();
    end
    check("mid_idx", 32'(rf_waddr), 32'd12);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_gnt = 0;
    for (int i = 0; i < 31; i++) begin
      random_inputs();
      step();
    end
    for (int i = 0; i < 100; i++) begin
      random_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
